freq_test_engine: RTL and testbench

- Parametrised successor to the single-mode monobit core: a streaming randomness tester for NIST SP800-22 style checks on a serial bit stream.
- Two run-time modes:
  - Monobit (frequency): |#ones − #zeros| over an N-bit sequence.
  - Block-frequency: counts M-bit sub-blocks whose ones count deviates from M/2 by more than a limit.
- Sits behind the TT top-level pin mux; ui_in supplies bit/valid/start/mode; uo_out/uio_out expose pass, busy and result fields.

---
 rtl/freq_test_engine_pkg.sv | 21 ++
 rtl/freq_test_engine_if.sv | 32 +++
 rtl/freq_test_engine_blk_freq_unit.sv | 61 ++++++
 rtl/freq_test_engine.sv | 133 +++++++++++++
 tb/tb_freq_test_engine.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/freq_test_engine_pkg.sv
// Shared types and sizing helpers for the frequency test engine.
package freq_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EVAL,
        DONE
    } state_e;

    typedef enum logic {
        MODE_MONO,
        MODE_BLOCK
    } mode_e;

    // A counter that must reach 2^log2_len needs one extra bit.
    function automatic int cnt_w(input int log2_len);
        return log2_len + 1;
    endfunction

endpackage

// File: rtl/freq_test_engine_if.sv
// Stream and result bundle between the pin mux and the test engine.
interface freq_test_engine_if #(
    parameter int SEQ_LEN_LOG2 = 7,
    parameter int BLK_LEN_LOG2 = 4
);
    import freq_test_pkg::*;

    logic start;
    logic mode;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;
    logic busy;
    logic result_valid;
    logic pass;
    logic [cnt_w(SEQ_LEN_LOG2)-1:0] abs_s;
    logic [cnt_w(SEQ_LEN_LOG2)-1:0] ones_count;
    logic [cnt_w(SEQ_LEN_LOG2-BLK_LEN_LOG2)-1:0] fail_blocks;

    modport master (
        output start, mode, bit_in, bit_valid,
        input  bit_ready, busy, result_valid, pass,
        input  abs_s, ones_count, fail_blocks
    );

    modport slave (
        input  start, mode, bit_in, bit_valid,
        output bit_ready, busy, result_valid, pass,
        output abs_s, ones_count, fail_blocks
    );

endinterface

// File: rtl/freq_test_engine_blk_freq_unit.sv
// Sub-block ones counter with deviation check and saturating fail count.
module blk_freq_unit
    import freq_test_pkg::*;
#(
    parameter int BLK_LEN_LOG2 = 4,
    parameter int FAIL_W       = 4,
    parameter int BLK_DEV      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              bit_acc,
    input  logic              bit_in,
    output logic [FAIL_W-1:0] fail_acc
);
    localparam int BW = cnt_w(BLK_LEN_LOG2);
    localparam logic [BW-1:0] HALF = BW'(2 ** (BLK_LEN_LOG2 - 1));

    logic [BLK_LEN_LOG2-1:0] blk_cnt_q, blk_cnt_d;
    logic [BW-1:0]           blk_ones_q, blk_ones_d;
    logic [FAIL_W-1:0]       fail_q, fail_d;
    logic [BW-1:0]           ones_new;
    logic [BW-1:0]           dev;
    logic                    blk_close;

    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        blk_ones_d = blk_ones_q;
        fail_d     = fail_q;
        // The closing bit is part of the block it closes.
        ones_new   = blk_ones_q + BW'(bit_in);
        dev        = (ones_new >= HALF) ? ones_new - HALF : HALF - ones_new;
        blk_close  = bit_acc && (blk_cnt_q == '1);
        if (clr) begin
            blk_cnt_d  = '0;
            blk_ones_d = '0;
            fail_d     = '0;
        end else if (bit_acc) begin
            blk_cnt_d  = blk_cnt_q + BLK_LEN_LOG2'(1);
            blk_ones_d = blk_close ? '0 : ones_new;
            if (blk_close && int'(dev) > BLK_DEV && fail_q != '1) begin
                fail_d = fail_q + FAIL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_q  <= '0;
            blk_ones_q <= '0;
            fail_q     <= '0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            blk_ones_q <= blk_ones_d;
            fail_q     <= fail_d;
        end
    end

    assign fail_acc = fail_q;

endmodule

// File: rtl/freq_test_engine.sv
// Streaming monobit / block-frequency randomness tester.
module freq_test_engine
    import freq_test_pkg::*;
#(
    parameter int SEQ_LEN_LOG2 = 7,
    parameter int BLK_LEN_LOG2 = 4,
    parameter int MONO_THRESH  = 29,
    parameter int BLK_DEV      = 4,
    parameter int BLK_FAIL_MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    freq_test_engine_if.slave bus
);
    localparam int SW = cnt_w(SEQ_LEN_LOG2);
    localparam int FW = cnt_w(SEQ_LEN_LOG2 - BLK_LEN_LOG2);
    localparam logic [SW:0] N_X = (SW + 1)'(2 ** SEQ_LEN_LOG2);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [SEQ_LEN_LOG2-1:0] seq_cnt_q, seq_cnt_d;
    logic [SW-1:0]           ones_q, ones_d;
    logic                    rv_q, rv_d;
    logic                    pass_q, pass_d;
    logic [SW-1:0]           abs_q, abs_d;
    logic [SW-1:0]           ocnt_q, ocnt_d;
    logic [FW-1:0]           fblk_q, fblk_d;

    logic [FW-1:0] fail_acc;
    logic          run;
    logic          bit_acc;
    logic          clr;
    logic          last_bit;
    logic [SW:0]   twice;
    logic [SW-1:0] abs_now;

    blk_freq_unit #(
        .BLK_LEN_LOG2 (BLK_LEN_LOG2),
        .FAIL_W       (FW),
        .BLK_DEV      (BLK_DEV)
    ) u_blk (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bit_acc  (bit_acc),
        .bit_in   (bus.bit_in),
        .fail_acc (fail_acc)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seq_cnt_d = seq_cnt_q;
        ones_d    = ones_q;
        rv_d      = rv_q;
        pass_d    = pass_q;
        abs_d     = abs_q;
        ocnt_d    = ocnt_q;
        fblk_d    = fblk_q;
        run       = (state_q == RUN);
        // A bit arriving with a restart belongs to the abandoned run.
        bit_acc   = ena && run && bus.bit_valid && !bus.start;
        clr       = ena && bus.start && (state_q != EVAL);
        last_bit  = bit_acc && (seq_cnt_q == '1);
        twice     = {ones_q, 1'b0};
        abs_now   = SW'((twice >= N_X) ? twice - N_X : N_X - twice);
        if (ena) begin
            rv_d = 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) state_d = RUN;
                end
                RUN: begin
                    if (bus.start)     state_d = RUN;
                    else if (last_bit) state_d = EVAL;
                end
                EVAL: begin
                    state_d = DONE;
                    rv_d    = 1'b1;
                    abs_d   = abs_now;
                    ocnt_d  = ones_q;
                    fblk_d  = fail_acc;
                    pass_d  = (mode_q == MODE_BLOCK)
                            ? (int'(fail_acc) <= BLK_FAIL_MAX)
                            : (int'(abs_now) <= MONO_THRESH);
                end
                default: state_d = IDLE;
            endcase
            if (clr) begin
                seq_cnt_d = '0;
                ones_d    = '0;
                mode_d    = mode_e'(bus.mode);
            end else if (bit_acc) begin
                seq_cnt_d = seq_cnt_q + SEQ_LEN_LOG2'(1);
                ones_d    = ones_q + SW'(bus.bit_in);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE_MONO;
            seq_cnt_q <= '0;
            ones_q    <= '0;
            rv_q      <= 1'b0;
            pass_q    <= 1'b0;
            abs_q     <= '0;
            ocnt_q    <= '0;
            fblk_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            seq_cnt_q <= seq_cnt_d;
            ones_q    <= ones_d;
            rv_q      <= rv_d;
            pass_q    <= pass_d;
            abs_q     <= abs_d;
            ocnt_q    <= ocnt_d;
            fblk_q    <= fblk_d;
        end
    end

    assign bus.bit_ready    = ena && run;
    assign bus.busy         = (state_q == RUN) || (state_q == EVAL);
    assign bus.result_valid = rv_q;
    assign bus.pass         = pass_q;
    assign bus.abs_s        = abs_q;
    assign bus.ones_count   = ocnt_q;
    assign bus.fail_blocks  = fblk_q;

endmodule

// File: tb/tb_freq_test_engine.sv
// Directed and randomized checks of freq_test_engine against a reference model.
module tb_freq_test_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;

    int checks = 0;
    int errors = 0;

    int e_ones, e_abs, e_fail, e_pass;

    freq_test_engine_if #(.SEQ_LEN_LOG2(7), .BLK_LEN_LOG2(4)) bus ();

    freq_test_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: counts straight from the bit list, 8 blocks of 16.
    task automatic model(input logic [127:0] sq, input bit m);
        int c, d;
        e_ones = 0;
        for (int i = 0; i < 128; i++) e_ones += int'(sq[i]);
        e_abs = 2 * e_ones - 128;
        if (e_abs < 0) e_abs = -e_abs;
        e_fail = 0;
        for (int b = 0; b < 8; b++) begin
            c = 0;
            for (int j = 0; j < 16; j++) c += int'(sq[b*16+j]);
            d = c - 8;
            if (d < 0) d = -d;
            if (d > 4) e_fail++;
        end
        e_pass = m ? int'(e_fail <= 1) : int'(e_abs <= 29);
    endtask

    task automatic start_run(input bit m, input bit with_bit);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.bit_valid = with_bit;
        bus.bit_in    = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic feed(input string tag, input logic [127:0] sq,
                        input int from, input int to, input bit gaps,
                        input int pause_at);
        for (int i = from; i < to; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                bus.bit_valid = 1'b0;
                bus.bit_in    = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if (i == pause_at) begin
                ena           = 1'b0;
                bus.bit_valid = 1'b1;
                bus.bit_in    = ~sq[i];
                repeat (5) begin
                    @(negedge clk);
                    chk({tag, " ready_ena_low"}, 32'(bus.bit_ready), 0);
                end
                ena = 1'b1;
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = sq[i];
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic finish(input string tag, input bit eval_start,
                          input bit hold_rv);
        chk({tag, " eval_busy"}, 32'(bus.busy), 1);
        chk({tag, " eval_rv"}, 32'(bus.result_valid), 0);
        chk({tag, " eval_ready"}, 32'(bus.bit_ready), 0);
        bus.start = eval_start;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " rv"}, 32'(bus.result_valid), 1);
        chk({tag, " ones"}, 32'(bus.ones_count), e_ones);
        chk({tag, " abs"}, 32'(bus.abs_s), e_abs);
        chk({tag, " fail"}, 32'(bus.fail_blocks), e_fail);
        chk({tag, " pass"}, 32'(bus.pass), e_pass);
        chk({tag, " done_busy"}, 32'(bus.busy), 0);
        if (hold_rv) begin
            ena = 1'b0;
            repeat (3) @(negedge clk);
            chk({tag, " rv_hold"}, 32'(bus.result_valid), 1);
            ena = 1'b1;
        end
        @(negedge clk);
        chk({tag, " rv_drop"}, 32'(bus.result_valid), 0);
    endtask

    task automatic full_run(input string tag, input bit m,
                            input logic [127:0] sq, input bit gaps,
                            input int pause_at, input bit eval_start,
                            input bit hold_rv);
        model(sq, m);
        start_run(m, 1'b0);
        feed(tag, sq, 0, 128, gaps, pause_at);
        finish(tag, eval_start, hold_rv);
    endtask

    logic [127:0] sq, sq2;
    bit           m;
    int           p_ones, p_abs, p_pass;

    initial begin
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(bus.bit_ready), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst rv", 32'(bus.result_valid), 0);
        chk("rst pass", 32'(bus.pass), 0);
        chk("rst abs", 32'(bus.abs_s), 0);
        chk("rst ones", 32'(bus.ones_count), 0);
        chk("rst fail", 32'(bus.fail_blocks), 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle ready", 32'(bus.bit_ready), 0);
            chk("idle busy", 32'(bus.busy), 0);
        end
        bus.bit_valid = 1'b0;

        full_run("all_ones", 1'b0, '1, 1'b0, -1, 1'b0, 1'b0);
        full_run("t79", 1'b0, (128'(1) << 79) - 128'(1), 1'b0, -1, 1'b1, 1'b0);
        full_run("t78", 1'b0, (128'(1) << 78) - 128'(1), 1'b0, -1, 1'b0, 1'b1);
        full_run("alt_mono", 1'b0, {64{2'b01}}, 1'b0, -1, 1'b0, 1'b0);
        full_run("alt_blk", 1'b1, {64{2'b01}}, 1'b0, -1, 1'b0, 1'b0);
        full_run("half_blk", 1'b1, {{64{1'b0}}, {64{1'b1}}}, 1'b0, -1, 1'b0, 1'b0);
        full_run("half_mono", 1'b0, {{64{1'b0}}, {64{1'b1}}}, 1'b0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            sq = {$urandom, $urandom, $urandom, $urandom};
            // Bias some runs so block failures actually occur.
            if (r[0]) sq = sq | {$urandom, $urandom, $urandom, $urandom};
            m  = 1'($urandom);
            full_run($sformatf("rnd%0d_gap", r), m, sq, 1'b1,
                     int'($urandom_range(10, 120)), 1'b0, 1'b0);
            full_run($sformatf("rnd%0d_flat", r), m, sq, 1'b0, -1, 1'b0, 1'b0);
        end

        p_ones = e_ones;
        p_abs  = e_abs;
        p_pass = e_pass;
        sq     = {$urandom, $urandom, $urandom, $urandom};
        start_run(1'b1, 1'b0);
        feed("abort", sq, 0, 50, 1'b0, -1);
        chk("abort hold ones", 32'(bus.ones_count), p_ones);
        chk("abort hold abs", 32'(bus.abs_s), p_abs);
        chk("abort hold pass", 32'(bus.pass), p_pass);
        chk("abort rv", 32'(bus.result_valid), 0);
        sq2 = {$urandom, $urandom, $urandom, $urandom};
        model(sq2, 1'b0);
        start_run(1'b0, 1'b1);
        feed("restart", sq2, 0, 127, 1'b0, -1);
        chk("restart busy", 32'(bus.busy), 1);
        chk("restart rv", 32'(bus.result_valid), 0);
        feed("restart", sq2, 127, 128, 1'b0, -1);
        finish("restart", 1'b0, 1'b0);

        full_run("pre_rst", 1'b0, 128'h0000_ffff_0000_ffff_0000_ffff_ffff_0fff,
                 1'b0, -1, 1'b0, 1'b0);
        start_run(1'b1, 1'b0);
        feed("rst70", sq, 0, 70, 1'b0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst70 ready", 32'(bus.bit_ready), 0);
        chk("rst70 busy", 32'(bus.busy), 0);
        chk("rst70 rv", 32'(bus.result_valid), 0);
        chk("rst70 pass", 32'(bus.pass), 0);
        chk("rst70 abs", 32'(bus.abs_s), 0);
        chk("rst70 ones", 32'(bus.ones_count), 0);
        chk("rst70 fail", 32'(bus.fail_blocks), 0);
        bus.bit_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst70 idle_rv", 32'(bus.result_valid), 0);
            chk("rst70 idle_busy", 32'(bus.busy), 0);
        end
        bus.bit_valid = 1'b0;

        full_run("post_rst", 1'b1, {$urandom, $urandom, $urandom, $urandom},
                 1'b1, 64, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
